// File: rtl/t06_multi_apple_placer.sv
// -----------------------------------------------------------------------------
// t06_multi_apple_placer
//
// Places one of NUM_APPLES apples on the playfield per request. A candidate
// {y,x} comes from an external random source; it is checked against every
// valid snake body segment (one segment per cycle), the exclusive playfield
// walls, the snake head, the other apple slots and an optional distance window
// around the head. Rejected candidates are retried until MAX_TRIES rejections
// have accumulated, after which FALLBACK_LOC is used instead.
//
// Ports
//   system_clk       : clock, rising edge
//   reset            : asynchronous reset, active-high
//   place_req        : one-cycle request to re-place slot apple_idx (IDLE only)
//   apple_idx        : slot to re-place; out-of-range values select slot 0
//   mode             : 00/11 any position, 01 near the head, 10 far from the head
//   candidate        : {y,x} candidate from the random source
//   snake_head_x/y   : head position
//   XMIN/XMAX/YMIN/YMAX : exclusive walls
//   snakeArrayX/Y    : packed body segments, segment k at [k*COORD_W +: COORD_W]
//   snake_length     : number of valid segments
//   apple_locations  : slot i at [i*2*COORD_W +: 2*COORD_W], {y,x}
//   busy             : placement in progress
//   done             : one-cycle pulse when a slot is written
//   fallback         : last placement used FALLBACK_LOC
// -----------------------------------------------------------------------------
module t06_multi_apple_placer #(
    parameter int NUM_APPLES   = 2,
    parameter int MAX_LENGTH   = 30,
    parameter int COORD_W      = 4,
    parameter int MAX_TRIES    = 15,
    parameter int NEAR_DIST    = 3,
    parameter int FAR_DIST     = 8,
    parameter     FALLBACK_LOC = 8'h68
) (
    input  logic                              system_clk,
    input  logic                              reset,
    input  logic                              place_req,
    input  logic [1:0]                        apple_idx,
    input  logic [1:0]                        mode,
    input  logic [2*COORD_W-1:0]              candidate,
    input  logic [COORD_W-1:0]                snake_head_x,
    input  logic [COORD_W-1:0]                snake_head_y,
    input  logic [COORD_W-1:0]                XMIN,
    input  logic [COORD_W-1:0]                XMAX,
    input  logic [COORD_W-1:0]                YMIN,
    input  logic [COORD_W-1:0]                YMAX,
    input  logic [MAX_LENGTH*COORD_W-1:0]     snakeArrayX,
    input  logic [MAX_LENGTH*COORD_W-1:0]     snakeArrayY,
    input  logic [4:0]                        snake_length,
    output logic [NUM_APPLES*2*COORD_W-1:0]   apple_locations,
    output logic                              busy,
    output logic                              done,
    output logic                              fallback
);

    localparam int TW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
    localparam logic [2*COORD_W-1:0] FB_LOC = (2*COORD_W)'(FALLBACK_LOC);

    // Distance limits once the search has been relaxed halfway through the tries.
    localparam int NEAR_RELAX = NEAR_DIST + 2;
    localparam int FAR_RELAX  = (FAR_DIST > 2) ? FAR_DIST - 2 : 0;
    localparam int RELAX_AT   = MAX_TRIES / 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SCAN   = 3'd2,
        DECIDE = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    fallback_q;
    logic [TW-1:0]           tries_q;
    logic [1:0]              idx_q;
    logic [1:0]              mode_q;
    logic [2*COORD_W-1:0]    cand_q;
    logic [4:0]              seg_ptr_q;
    logic                    hit_q;
    logic [2*COORD_W-1:0]    sel_q;
    logic [2*COORD_W-1:0]    loc_q [NUM_APPLES];

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // One extra bit keeps the sum of two full-range differences exact.
    function automatic logic [COORD_W:0] manhattan(input logic [COORD_W-1:0] ax,
                                                   input logic [COORD_W-1:0] ay,
                                                   input logic [COORD_W-1:0] bx,
                                                   input logic [COORD_W-1:0] by);
        return {1'b0, abs_diff(ax, bx)} + {1'b0, abs_diff(ay, by)};
    endfunction

    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    assign cand_x = cand_q[COORD_W-1:0];
    assign cand_y = cand_q[2*COORD_W-1:COORD_W];

    // Body segment addressed by the scan pointer.
    logic [COORD_W-1:0] seg_x_d;
    logic [COORD_W-1:0] seg_y_d;
    always_comb begin
        seg_x_d = '0;
        seg_y_d = '0;
        for (int k = 0; k < MAX_LENGTH; k++) begin
            if (seg_ptr_q == 5'(k)) begin
                seg_x_d = snakeArrayX[k*COORD_W +: COORD_W];
                seg_y_d = snakeArrayY[k*COORD_W +: COORD_W];
            end
        end
    end

    logic       seg_match_d;
    logic [4:0] scan_len_d;
    logic       scan_last_d;
    assign seg_match_d = (seg_x_d == cand_x) && (seg_y_d == cand_y);
    // snake_length may exceed the storage depth; only stored segments are scanned.
    assign scan_len_d  = (int'(snake_length) > MAX_LENGTH) ? 5'(MAX_LENGTH) : snake_length;
    assign scan_last_d = (seg_ptr_q == scan_len_d - 5'd1);

    // Candidate already occupied by a different apple slot.
    logic slot_clash_d;
    always_comb begin
        slot_clash_d = 1'b0;
        for (int j = 0; j < NUM_APPLES; j++) begin
            if ((idx_q != 2'(j)) && (loc_q[j] == cand_q)) begin
                slot_clash_d = 1'b1;
            end
        end
    end

    logic [COORD_W:0] dist_d;
    logic             relaxed_d;
    logic             out_of_field_d;
    logic             on_head_d;
    logic             dist_reject_d;
    logic             reject_d;

    assign dist_d         = manhattan(cand_x, cand_y, snake_head_x, snake_head_y);
    assign relaxed_d      = (int'(tries_q) >= RELAX_AT);
    assign out_of_field_d = (cand_x <= XMIN) || (cand_x >= XMAX) ||
                            (cand_y <= YMIN) || (cand_y >= YMAX);
    assign on_head_d      = (cand_x == snake_head_x) && (cand_y == snake_head_y);

    always_comb begin
        dist_reject_d = 1'b0;
        if (mode_q == 2'b01) begin
            dist_reject_d = int'(dist_d) > (relaxed_d ? NEAR_RELAX : NEAR_DIST);
        end else if (mode_q == 2'b10) begin
            dist_reject_d = int'(dist_d) < (relaxed_d ? FAR_RELAX : FAR_DIST);
        end
    end

    assign reject_d = hit_q || out_of_field_d || on_head_d || slot_clash_d || dist_reject_d;

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fallback_q <= 1'b0;
            tries_q    <= '0;
            idx_q      <= '0;
            mode_q     <= '0;
            cand_q     <= '0;
            seg_ptr_q  <= '0;
            hit_q      <= 1'b0;
            sel_q      <= '0;
            for (int i = 0; i < NUM_APPLES; i++) begin
                loc_q[i] <= {COORD_W'(2), COORD_W'(2 + 2*i)};
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (place_req) begin
                        idx_q   <= (int'(apple_idx) < NUM_APPLES) ? apple_idx : 2'd0;
                        mode_q  <= (mode == 2'b11) ? 2'b00 : mode;
                        tries_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    cand_q    <= candidate;
                    seg_ptr_q <= '0;
                    hit_q     <= 1'b0;
                    state_q   <= (snake_length == 5'd0) ? DECIDE : SCAN;
                end
                SCAN: begin
                    if (seg_match_d) begin
                        hit_q <= 1'b1;
                    end
                    if (scan_last_d) begin
                        state_q <= DECIDE;
                    end else begin
                        seg_ptr_q <= seg_ptr_q + 5'd1;
                    end
                end
                DECIDE: begin
                    if (reject_d) begin
                        if (int'(tries_q) < MAX_TRIES) begin
                            tries_q <= tries_q + TW'(1);
                            state_q <= FETCH;
                        end else begin
                            sel_q      <= FB_LOC;
                            fallback_q <= 1'b1;
                            state_q    <= COMMIT;
                        end
                    end else begin
                        sel_q      <= cand_q;
                        fallback_q <= 1'b0;
                        state_q    <= COMMIT;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_APPLES; i++) begin
                        if (idx_q == 2'(i)) begin
                            loc_q[i] <= sel_q;
                        end
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        apple_locations = '0;
        for (int i = 0; i < NUM_APPLES; i++) begin
            apple_locations[i*2*COORD_W +: 2*COORD_W] = loc_q[i];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign fallback = fallback_q;

endmodule

// File: tb/tb_t06_multi_apple_placer.sv
// -----------------------------------------------------------------------------
// Testbench for t06_multi_apple_placer: directed scenarios plus randomized
// placements scored against a rule-level reference model.
// -----------------------------------------------------------------------------
module tb_t06_multi_apple_placer;

    localparam int NA = 2;
    localparam int ML = 30;
    localparam int CW = 4;
    localparam int MT = 15;
    localparam int ND = 3;
    localparam int FD = 8;
    localparam logic [7:0] FB = 8'h68;

    logic                 system_clk = 1'b0;
    logic                 reset;
    logic                 place_req;
    logic [1:0]           apple_idx;
    logic [1:0]           mode;
    logic [2*CW-1:0]      candidate;
    logic [CW-1:0]        snake_head_x;
    logic [CW-1:0]        snake_head_y;
    logic [CW-1:0]        XMIN;
    logic [CW-1:0]        XMAX;
    logic [CW-1:0]        YMIN;
    logic [CW-1:0]        YMAX;
    logic [ML*CW-1:0]     snakeArrayX;
    logic [ML*CW-1:0]     snakeArrayY;
    logic [4:0]           snake_length;
    logic [NA*2*CW-1:0]   apple_locations;
    logic                 busy;
    logic                 done;
    logic                 fallback;

    t06_multi_apple_placer #(
        .NUM_APPLES(NA), .MAX_LENGTH(ML), .COORD_W(CW), .MAX_TRIES(MT),
        .NEAR_DIST(ND), .FAR_DIST(FD), .FALLBACK_LOC(FB)
    ) dut (
        .system_clk(system_clk), .reset(reset), .place_req(place_req),
        .apple_idx(apple_idx), .mode(mode), .candidate(candidate),
        .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
        .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX),
        .snakeArrayX(snakeArrayX), .snakeArrayY(snakeArrayY),
        .snake_length(snake_length), .apple_locations(apple_locations),
        .busy(busy), .done(done), .fallback(fallback)
    );

    always #5 system_clk = ~system_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Playfield picture seen by the reference model.
    int bx[ML];
    int by[ML];
    int blen;
    int hx, hy;
    int xmin, xmax, ymin, ymax;
    int ref_loc[NA];
    int cand_list[MT+1];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void reset_model();
        for (int i = 0; i < NA; i++) ref_loc[i] = (2 << 4) | (2 + 2*i);
    endfunction

    // Walk the candidate list in evaluation order and apply every placement rule.
    function automatic void model(input int idx, input int md,
                                  output int sel, output int fb, output int evals);
        int nseg;
        nseg = (blen > ML) ? ML : blen;
        for (int k = 0; k <= MT; k++) begin
            int c, x, y, d;
            bit ok;
            c = cand_list[k];
            x = c & 15;
            y = (c >> 4) & 15;
            ok = 1;
            for (int s = 0; s < nseg; s++)
                if (bx[s] == x && by[s] == y) ok = 0;
            if (x <= xmin || x >= xmax || y <= ymin || y >= ymax) ok = 0;
            if (x == hx && y == hy) ok = 0;
            for (int j = 0; j < NA; j++)
                if (j != idx && ref_loc[j] == c) ok = 0;
            d = iabs(x - hx) + iabs(y - hy);
            if (md == 1 && d > ((k >= MT/2) ? ND + 2 : ND)) ok = 0;
            if (md == 2 && d < ((k >= MT/2) ? ((FD > 2) ? FD - 2 : 0) : FD)) ok = 0;
            if (ok) begin
                sel = c; fb = 0; evals = k + 1;
                return;
            end
        end
        sel = int'(FB); fb = 1; evals = MT + 1;
    endfunction

    function automatic logic [NA*8-1:0] exp_vec();
        logic [NA*8-1:0] v;
        v = '0;
        for (int i = 0; i < NA; i++) v[i*8 +: 8] = 8'(ref_loc[i]);
        return v;
    endfunction

    task automatic apply_inputs();
        for (int k = 0; k < ML; k++) begin
            snakeArrayX[k*CW +: CW] = CW'(bx[k]);
            snakeArrayY[k*CW +: CW] = CW'(by[k]);
        end
        snake_length = 5'(blen);
        snake_head_x = CW'(hx);
        snake_head_y = CW'(hy);
        XMIN = CW'(xmin); XMAX = CW'(xmax);
        YMIN = CW'(ymin); YMAX = CW'(ymax);
    endtask

    // Issue one placement; candidate list entry k is presented for evaluation k,
    // whose fetch happens 1 + k*(segments+2) edges after the request edge.
    task automatic do_place(input int idx_in, input int md_in, input bit spam,
                            output int lat_obs);
        int eidx, emd, sel, fb, evals, lc, per, lat, k;
        eidx = (idx_in >= NA) ? 0 : idx_in;
        emd  = (md_in == 3) ? 0 : md_in;
        model(eidx, emd, sel, fb, evals);
        lc  = (blen > ML) ? ML : blen;
        per = lc + 2;
        lat = (evals - 1) * per + 3 + lc;
        apply_inputs();
        @(negedge system_clk);
        place_req = 1'b1;
        apple_idx = 2'(idx_in);
        mode      = 2'(md_in);
        candidate = 8'(cand_list[0]);
        @(posedge system_clk); #1;
        place_req = 1'b0;
        check("busy_start", {31'd0, busy}, 32'd1);
        lat_obs = -1;
        for (int n = 1; n <= lat + 8; n++) begin
            k = (n - 1) / per;
            if (k > MT) k = MT;
            candidate = 8'(cand_list[k]);
            if (spam && n == 2) begin
                place_req = 1'b1;
                apple_idx = 2'(1 - eidx);
                mode      = 2'(emd ^ 1);
            end else begin
                place_req = 1'b0;
            end
            @(posedge system_clk); #1;
            if (done) begin
                lat_obs = n;
                break;
            end
        end
        place_req = 1'b0;
        if (lat_obs < 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            ref_loc[eidx] = sel;
            check("latency", lat_obs, lat);
            check("locations", {16'd0, apple_locations}, {16'd0, exp_vec()});
            check("fallback", {31'd0, fallback}, fb);
            check("busy_end", {31'd0, busy}, 32'd0);
            @(posedge system_clk); #1;
            check("done_pulse", {31'd0, done}, 32'd0);
        end
    endtask

    task automatic fill_cands(input int v);
        for (int k = 0; k <= MT; k++) cand_list[k] = v;
    endtask

    task automatic default_body();
        blen = 3;
        for (int k = 0; k < ML; k++) begin
            bx[k] = 7; by[k] = 7;   // unused segments sit on 8'h77
        end
        bx[0] = 1; by[0] = 1;
        bx[1] = 1; by[1] = 2;
        bx[2] = 1; by[2] = 3;
    endtask

    int lat;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; place_req = 1'b0; apple_idx = '0; mode = '0; candidate = '0;
        xmin = 0; xmax = 15; ymin = 0; ymax = 15;
        hx = 1; hy = 1;
        default_body();
        reset_model();
        apply_inputs();
        repeat (3) @(posedge system_clk);
        #1;
        check("rst_locations", {16'd0, apple_locations}, 32'h2422);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fallback", {31'd0, fallback}, 32'd0);
        @(negedge system_clk);
        reset = 1'b0;

        // Plain accept on the first try.
        fill_cands(8'h77);
        do_place(1, 0, 1'b0, lat);
        check("first_try_lat", lat, 6);
        check("first_try_slot1", {24'd0, apple_locations[15:8]}, 32'h77);
        check("first_try_fb", {31'd0, fallback}, 32'd0);

        // Candidate on body segment 2 twice, then a free square.
        fill_cands(8'h99);
        cand_list[0] = 8'h31; cand_list[1] = 8'h31;
        do_place(0, 0, 1'b0, lat);
        check("body_hit_slot0", {24'd0, apple_locations[7:0]}, 32'h99);
        check("body_hit_lat", lat, 16);

        // Near mode with an unreachable candidate exhausts the tries.
        hx = 5; hy = 5;
        fill_cands(8'hCC);
        do_place(0, 1, 1'b0, lat);
        check("exhaust_slot0", {24'd0, apple_locations[7:0]}, 32'h68);
        check("exhaust_fb", {31'd0, fallback}, 32'd1);
        check("exhaust_lat", lat, 81);

        // Far mode: distance 4 always rejected, distance 7 accepted once relaxed.
        fill_cands(8'h89);
        for (int k = 0; k < 7; k++) cand_list[k] = 8'h95;
        do_place(1, 2, 1'b0, lat);
        check("far_slot1", {24'd0, apple_locations[15:8]}, 32'h89);
        check("far_fb", {31'd0, fallback}, 32'd0);
        check("far_lat", lat, 41);

        // Clash with the other slot, with a stray request while busy.
        fill_cands(8'hA3);
        cand_list[0] = ref_loc[0];
        do_place(1, 0, 1'b1, lat);
        check("clash_slot1", {24'd0, apple_locations[15:8]}, 32'hA3);
        check("clash_slot0", {24'd0, apple_locations[7:0]}, 32'h68);
        check("clash_lat", lat, 11);
        repeat (3) @(posedge system_clk);
        #1;
        check("stray_ignored", {31'd0, busy}, 32'd0);

        // Leave fallback set, then reset in the middle of a scan.
        fill_cands(8'hCC);
        do_place(1, 1, 1'b0, lat);
        check("pre_reset_fb", {31'd0, fallback}, 32'd1);
        blen = 5;
        apply_inputs();
        fill_cands(8'hB4);
        @(negedge system_clk);
        place_req = 1'b1; apple_idx = 2'd0; mode = 2'd0; candidate = 8'hB4;
        @(posedge system_clk); #1;
        place_req = 1'b0;
        @(posedge system_clk);
        @(posedge system_clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_fb", {31'd0, fallback}, 32'd0);
        check("midrst_locations", {16'd0, apple_locations}, 32'h2422);
        @(negedge system_clk);
        reset = 1'b0;
        reset_model();
        default_body();
        do_place(3, 3, 1'b0, lat);
        check("post_rst_slot0", {24'd0, apple_locations[7:0]}, 32'hB4);

        // Randomized placements.
        for (int it = 0; it < 30; it++) begin
            int idx_r, md_r;
            blen = $urandom_range(1, 10);
            for (int k = 0; k < ML; k++) begin
                bx[k] = $urandom_range(0, 15);
                by[k] = $urandom_range(0, 15);
            end
            hx = $urandom_range(0, 15); hy = $urandom_range(0, 15);
            xmin = $urandom_range(0, 3); xmax = $urandom_range(11, 15);
            ymin = $urandom_range(0, 3); ymax = $urandom_range(11, 15);
            idx_r = $urandom_range(0, 3);
            md_r  = $urandom_range(0, 3);
            for (int k = 0; k <= MT; k++) begin
                int s, r;
                r = $urandom_range(0, 9);
                s = $urandom_range(0, blen - 1);
                case (r)
                    0, 1: cand_list[k] = (by[s] << 4) | bx[s];
                    2:    cand_list[k] = (hy << 4) | hx;
                    3:    cand_list[k] = ref_loc[$urandom_range(0, NA - 1)];
                    default: cand_list[k] = $urandom_range(0, 255);
                endcase
            end
            do_place(idx_r, md_r, ($urandom_range(0, 3) == 0), lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
